// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants for the data-memory arbiter.
// State encodings, requester ids and default bus widths.
package dm_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC,
    RESP = ST_RESP
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_if.sv
// dm_arb_if: one requester port of the data-memory arbiter.
// master = requester (req/we/addr/wdata out), slave = arbiter (ack/rdata out).
interface dm_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/dm_arb_rr.sv
// dm_arb_rr: combinational 2-way round-robin picker.
// Ports: req_i[1:0], last_grant_i, lock_i -> gnt_valid_o, gnt_id_o.
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic [1:0] eff;

  // lock masks the debug requester entirely
  assign eff = {req_i[REQ_DBG] & ~lock_i,
                req_i[REQ_CPU]};

  assign gnt_valid_o = |eff;

  always_comb begin
    gnt_id_o = REQ_CPU;
    case (eff)
      2'b11:   gnt_id_o = ~last_grant_i;
      2'b10:   gnt_id_o = REQ_DBG;
      default: gnt_id_o = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dm_arb.sv
// dm_arb: two-requester controller for a single-port word memory.
// Ports: clk, rst, cpu/dbg (dm_arb_if.slave), mem_addr/mem_din/mem_we/mem_dout;
// cpu_lock only when DM_ARB_LOCK_EN is defined (atomic CPU sequences).
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dm_arb_if.slave           cpu,
  dm_arb_if.slave           dbg,
`ifdef DM_ARB_LOCK_EN
  input  logic              cpu_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q;
  logic              last_q;
  logic              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              lock;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

`ifdef DM_ARB_LOCK_EN
  logic locked_q;
  logic lock_lat_q;
  assign lock = locked_q;
`else
  assign lock = 1'b0;
`endif

  dm_arb_rr u_rr (
    .req_i        ({dbg.req, cpu.req}),
    .last_grant_i (last_q),
    .lock_i       (lock),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  assign we_d    = (gnt_id == REQ_DBG) ? dbg.we    : cpu.we;
  assign addr_d  = (gnt_id == REQ_DBG) ? dbg.addr  : cpu.addr;
  assign wdata_d = (gnt_id == REQ_DBG) ? dbg.wdata : cpu.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= REQ_DBG;
      gnt_q       <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
`ifdef DM_ARB_LOCK_EN
      locked_q    <= 1'b0;
      lock_lat_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_we_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          if (gnt_valid) begin
            gnt_q    <= gnt_id;
            last_q   <= gnt_id;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            // write strobe is registered so it is high for ACC only
            mem_we_q <= we_d;
            state_q  <= ACC;
`ifdef DM_ARB_LOCK_EN
            if (gnt_id == REQ_CPU) begin
              lock_lat_q <= cpu_lock;
              if (cpu_lock) locked_q <= 1'b1;
            end
`endif
          end
        end
        ACC: begin
          mem_we_q <= 1'b0;
          if (!we_q) begin
            if (gnt_q == REQ_DBG) dbg_rdata_q <= mem_dout;
            else                  cpu_rdata_q <= mem_dout;
          end
          cpu_ack_q <= (gnt_q == REQ_CPU);
          dbg_ack_q <= (gnt_q == REQ_DBG);
          state_q   <= RESP;
        end
        RESP: begin
          mem_we_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= IDLE;
`ifdef DM_ARB_LOCK_EN
          if (gnt_q == REQ_CPU && !lock_lat_q)
            locked_q <= 1'b0;
`endif
        end
        default: begin
          mem_we_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu.ack   = cpu_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dbg.ack   = dbg_ack_q;
  assign dbg.rdata = dbg_rdata_q;

endmodule
